// File: rtl/signed_frame_accumulator.sv
// Frame reducer: sums FRAME_LEN signed samples and counts overflowing adds. The result is
// valid the cycle after the last accept. in_ready is low while a result waits on out_ready.
module signed_frame_accumulator #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4,
  parameter int SATURATE  = 0,
  localparam int CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [CW-1:0]    out_ovf_count
);

  localparam int              MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST    = CW'(FRAME_LEN - 1);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             ovf_sticky;
  logic [CW-1:0]    ovf_cnt;
  logic [CW-1:0]    smp_cnt;

  logic [WIDTH-1:0] sum_raw;
  logic             ovf;
  logic [WIDTH-1:0] acc_nxt;
  logic             sticky_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    sum_raw    = acc + in_data;
    ovf        = (acc[MSB] == in_data[MSB]) && (sum_raw[MSB] != acc[MSB]);
    acc_nxt    = sum_raw;
    // Clamp direction follows the accumulator sign, since overflow needs both operands alike.
    if ((SATURATE != 0) && ovf) begin
      acc_nxt = acc[MSB] ? SAT_MIN : SAT_MAX;
    end
    sticky_nxt = ovf_sticky | ovf;
    cnt_nxt    = ovf_cnt + CW'(ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACCUM;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_sum       <= '0;
      out_overflow  <= 1'b0;
      out_ovf_count <= '0;
      acc           <= '0;
      ovf_sticky    <= 1'b0;
      ovf_cnt       <= '0;
      smp_cnt       <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && (smp_cnt == LAST)) begin
            out_sum       <= acc_nxt;
            out_overflow  <= sticky_nxt;
            out_ovf_count <= cnt_nxt;
            acc           <= '0;
            ovf_sticky    <= 1'b0;
            ovf_cnt       <= '0;
            smp_cnt       <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b1;
            state         <= OUTPUT;
          end else begin
            if (accept) begin
              acc        <= acc_nxt;
              ovf_sticky <= sticky_nxt;
              ovf_cnt    <= cnt_nxt;
              smp_cnt    <= smp_cnt + CW'(1);
            end
            // Also covers the first edge after reset release.
            in_ready <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Directed bench for signed_frame_accumulator: wrap and saturate instances share stimulus,
// and a negedge monitor checks each handshaken result against a queue of expected frames.
module tb_signed_frame_accumulator;

  typedef struct packed {
    logic [3:0] sum;
    logic       ovf;
    logic [2:0] cnt;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b1;

  logic       in_ready0, out_valid0, out_overflow0;
  logic [3:0] out_sum0;
  logic [2:0] out_ovf_count0;
  logic       in_ready1, out_valid1, out_overflow1;
  logic [3:0] out_sum1;
  logic [2:0] out_ovf_count1;

  int errors = 0;
  int checks = 0;
  res_t q0[$];
  res_t q1[$];

  always #5 clk = ~clk;

  signed_frame_accumulator #(.WIDTH(4), .FRAME_LEN(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
    .out_overflow(out_overflow0), .out_ovf_count(out_ovf_count0));

  signed_frame_accumulator #(.WIDTH(4), .FRAME_LEN(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
    .out_overflow(out_overflow1), .out_ovf_count(out_ovf_count1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Both instances share timing, so dut0's in_ready gates the stimulus.
  task automatic send(input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
    @(posedge clk);
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input res_t e0, input res_t e1);
    q0.push_back(e0);
    q1.push_back(e1);
    send(a); send(b); send(c); send(d);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_ready && out_valid0) begin
      if (q0.size() == 0) chk("unexpected_out0", 32'(1), 32'(0));
      else begin
        res_t e;
        e = q0.pop_front();
        chk("wrap_result", {out_sum0, out_overflow0, out_ovf_count0}, 32'(e));
      end
    end
    if (!rst && out_ready && out_valid1) begin
      if (q1.size() == 0) chk("unexpected_out1", 32'(1), 32'(0));
      else begin
        res_t e;
        e = q1.pop_front();
        chk("sat_result", {out_sum1, out_overflow1, out_ovf_count1}, 32'(e));
      end
    end
  end

  initial begin
    #2;
    chk("reset_in_ready", 32'(in_ready0), 32'(0));
    chk("reset_out_valid", 32'(out_valid0), 32'(0));
    chk("reset_outputs", {out_sum0, out_overflow0, out_ovf_count0}, 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready0), 32'(1));

    // 1+2+3+1 = 7, no overflow; check one-cycle latency and single stall cycle.
    frame(4'd1, 4'd2, 4'd3, 4'd1, '{4'd7, 1'b0, 3'd0}, '{4'd7, 1'b0, 3'd0});
    @(negedge clk);
    in_valid = 1'b0;
    chk("valid_after_last", 32'(out_valid0), 32'(1));
    chk("ready_low_in_output", 32'(in_ready0), 32'(0));
    @(negedge clk);
    chk("ready_back_high", 32'(in_ready0), 32'(1));
    chk("valid_dropped", 32'(out_valid0), 32'(0));

    // 7+1 overflows once: wrap -> -8, saturate -> 7.
    frame(4'd7, 4'd1, 4'd0, 4'd0, '{4'b1000, 1'b1, 3'd1}, '{4'b0111, 1'b1, 3'd1});
    // -8,-1,1,0: wrap goes -8,7,-8,-8 with two overflows; saturate -8,-8,-7,-7 with one.
    frame(4'b1000, 4'b1111, 4'd1, 4'd0, '{4'b1000, 1'b1, 3'd2}, '{4'b1001, 1'b1, 3'd1});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // Back-pressure: result must hold while stalled samples of 5 are ignored.
    out_ready = 1'b0;
    frame(4'd1, 4'd2, 4'd3, 4'd1, '{4'd7, 1'b0, 3'd0}, '{4'd7, 1'b0, 3'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'd5;
      chk("stall_valid", 32'(out_valid0), 32'(1));
      chk("stall_ready", 32'(in_ready0), 32'(0));
      chk("stall_hold", {out_sum0, out_overflow0, out_ovf_count0}, {4'd7, 1'b0, 3'd0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    frame(4'd1, 4'd1, 4'd1, 4'd1, '{4'd4, 1'b0, 3'd0}, '{4'd4, 1'b0, 3'd0});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset after two accepts discards the partial frame without an output event.
    send(4'd3);
    send(4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {out_valid0, in_ready0, out_sum0, out_overflow0, out_ovf_count0},
        32'(0));
    chk("async_reset_sat", {out_valid1, in_ready1, out_sum1, out_overflow1, out_ovf_count1},
        32'(0));
    @(negedge clk);
    rst = 1'b0;
    frame(4'd1, 4'd1, 4'd1, 4'd1, '{4'd4, 1'b0, 3'd0}, '{4'd4, 1'b0, 3'd0});
    @(negedge clk);
    in_valid = 1'b0;

    repeat (6) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got %0t expected < 20000", $time);
    $fatal(1, "timeout");
  end

endmodule
